// File: rtl/rdl_subreg_counter.sv
// Register-field counter: CPU write / read-clear, HW load, incr/decr with wrap or saturation.
// One-cycle update latency; no backpressure, every strobe is accepted on the cycle it is seen.

package rdl_subreg_pkg;
  typedef enum logic {
    OnReadNone  = 1'b0,
    OnReadClear = 1'b1
  } on_read_e;
endpackage

module rdl_subreg_counter #(
  parameter int unsigned             DW            = 8,
  parameter int unsigned             IncrW         = 1,
  parameter int unsigned             DecrW         = 1,
  parameter logic [DW-1:0]           ResetValue    = '0,
  parameter bit                      Saturate      = 1'b0,
  parameter logic [DW-1:0]           IncrSatValue  = '1,
  parameter logic [DW-1:0]           DecrSatValue  = '0,
  parameter logic [DW-1:0]           IncrThreshold = '1,
  parameter logic [DW-1:0]           DecrThreshold = '0,
  parameter rdl_subreg_pkg::on_read_e OnRead       = rdl_subreg_pkg::OnReadNone
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [DW-1:0]    wd,
  input  logic             re,
  input  logic             de,
  input  logic [DW-1:0]    d,
  input  logic             incr,
  input  logic [IncrW-1:0] incr_value,
  input  logic             decr,
  input  logic [DecrW-1:0] decr_value,
  output logic [DW-1:0]    q,
  output logic [DW-1:0]    qs,
  output logic             qe,
  output logic             overflow,
  output logic             underflow,
  output logic             incr_sat,
  output logic             decr_sat,
  output logic             incr_thr,
  output logic             decr_thr
);

  // Two guard bits: one for carry past 2^DW-1, one for sign below zero.
  localparam int unsigned SW = DW + 2;

  localparam logic signed [SW-1:0] WrapMax = $signed({2'b00, {DW{1'b1}}});
  localparam logic signed [SW-1:0] HiLim   = $signed({2'b00, IncrSatValue});
  localparam logic signed [SW-1:0] LoLim   = $signed({2'b00, DecrSatValue});
  localparam bit                   RdClr   = (OnRead == rdl_subreg_pkg::OnReadClear);

  logic [DW-1:0]        cnt_q, cnt_d;
  logic                 qe_q, qe_d;
  logic                 ovf_q, ovf_d;
  logic                 unf_q, unf_d;

  logic signed [SW-1:0] cur_s, inc_s, dec_s, sum_s;

  always_comb begin
    cur_s = $signed({2'b00, cnt_q});
    inc_s = incr ? $signed({{(SW-IncrW){1'b0}}, incr_value}) : '0;
    dec_s = decr ? $signed({{(SW-DecrW){1'b0}}, decr_value}) : '0;
    sum_s = cur_s + inc_s - dec_s;

    cnt_d = cnt_q;
    qe_d  = 1'b0;
    ovf_d = 1'b0;
    unf_d = 1'b0;

    if (we) begin
      cnt_d = wd;
      qe_d  = 1'b1;
    end else if (re && RdClr) begin
      cnt_d = '0;
      qe_d  = 1'b1;
    end else if (de) begin
      cnt_d = d;
    end else if (sum_s != cur_s) begin
      // Cancelling or zero-valued strobes fall through here untouched.
      if (Saturate) begin
        if (sum_s > HiLim) begin
          cnt_d = IncrSatValue;
          ovf_d = 1'b1;
        end else if (sum_s < LoLim) begin
          cnt_d = DecrSatValue;
          unf_d = 1'b1;
        end else begin
          cnt_d = sum_s[DW-1:0];
        end
      end else begin
        cnt_d = sum_s[DW-1:0];
        ovf_d = (sum_s > WrapMax);
        unf_d = sum_s[SW-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= ResetValue;
      qe_q  <= 1'b0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      qe_q  <= qe_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign q         = cnt_q;
  assign qs        = cnt_q;
  assign qe        = qe_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

  assign incr_sat  = Saturate && (cnt_q == IncrSatValue);
  assign decr_sat  = Saturate && (cnt_q == DecrSatValue);
  assign incr_thr  = (cnt_q >= IncrThreshold);
  assign decr_thr  = (cnt_q <= DecrThreshold);

endmodule

// File: tb/tb_rdl_subreg_counter.sv
// Bench for rdl_subreg_counter: a wrapping/no-clear instance and a saturating/read-clear
// instance share stimulus; directed table, async-reset sequence, then random vs. a reference model.

module tb_rdl_subreg_counter;

  localparam int HI  = 8'hF0;
  localparam int LO  = 8'h08;
  localparam int ITH = 8'hC0;
  localparam int DTH = 8'h20;
  localparam int RV  = 8'h10;

  logic       clk, rst;
  logic       we, re, de, incr, decr;
  logic [7:0] wd, d, iv, dv;

  logic [7:0] q0, qs0, q1, qs1;
  logic       qe0, ov0, un0, isat0, dsat0, ithr0, dthr0;
  logic       qe1, ov1, un1, isat1, dsat1, ithr1, dthr1;

  int n_checks = 0;
  int n_pass   = 0;

  rdl_subreg_counter #(
    .DW(8), .IncrW(8), .DecrW(8), .ResetValue(8'h10), .Saturate(1'b0),
    .IncrSatValue(8'hF0), .DecrSatValue(8'h08),
    .IncrThreshold(8'hC0), .DecrThreshold(8'h20),
    .OnRead(rdl_subreg_pkg::OnReadNone)
  ) u_wrap (
    .clk(clk), .rst(rst), .we(we), .wd(wd), .re(re), .de(de), .d(d),
    .incr(incr), .incr_value(iv), .decr(decr), .decr_value(dv),
    .q(q0), .qs(qs0), .qe(qe0), .overflow(ov0), .underflow(un0),
    .incr_sat(isat0), .decr_sat(dsat0), .incr_thr(ithr0), .decr_thr(dthr0)
  );

  rdl_subreg_counter #(
    .DW(8), .IncrW(8), .DecrW(8), .ResetValue(8'h10), .Saturate(1'b1),
    .IncrSatValue(8'hF0), .DecrSatValue(8'h08),
    .IncrThreshold(8'hC0), .DecrThreshold(8'h20),
    .OnRead(rdl_subreg_pkg::OnReadClear)
  ) u_sat (
    .clk(clk), .rst(rst), .we(we), .wd(wd), .re(re), .de(de), .d(d),
    .incr(incr), .incr_value(iv), .decr(decr), .decr_value(dv),
    .q(q1), .qs(qs1), .qe(qe1), .overflow(ov1), .underflow(un1),
    .incr_sat(isat1), .decr_sat(dsat1), .incr_thr(ithr1), .decr_thr(dthr1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       we;  logic [7:0] wd;
    logic       re;
    logic       de;  logic [7:0] d;
    logic       incr; logic [7:0] iv;
    logic       decr; logic [7:0] dv;
    logic [7:0] e0;  logic eov0; logic eun0; logic eqe0;
    logic [7:0] e1;  logic eov1; logic eun1; logic eqe1;
  } vec_t;

  typedef struct {
    int q;
    bit ov;
    bit un;
    bit qe;
  } res_t;

  vec_t vt[16];

  // Next-state rules straight from the field definition, in plain integer arithmetic.
  function automatic res_t model(input int cur, input bit sat, input bit clr, input vec_t v);
    res_t o;
    int   r;
    o.q  = cur;
    o.ov = 1'b0;
    o.un = 1'b0;
    o.qe = 1'b0;
    r = cur + (v.incr ? int'(v.iv) : 0) - (v.decr ? int'(v.dv) : 0);
    if (v.we) begin
      o.q  = int'(v.wd);
      o.qe = 1'b1;
    end else if (v.re && clr) begin
      o.q  = 0;
      o.qe = 1'b1;
    end else if (v.de) begin
      o.q = int'(v.d);
    end else if (r != cur) begin
      if (sat) begin
        if (r > HI) begin
          o.q = HI; o.ov = 1'b1;
        end else if (r < LO) begin
          o.q = LO; o.un = 1'b1;
        end else begin
          o.q = r;
        end
      end else begin
        o.q  = (r + 512) % 256;
        o.ov = (r > 255);
        o.un = (r < 0);
      end
    end
    return o;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic check_all(input string tag,
                           input int e0, input bit eov0, input bit eun0, input bit eqe0,
                           input int e1, input bit eov1, input bit eun1, input bit eqe1);
    chk({tag, " q0"},    32'(q0),    32'(e0));
    chk({tag, " qs0"},   32'(qs0),   32'(e0));
    chk({tag, " ovf0"},  32'(ov0),   32'(eov0));
    chk({tag, " unf0"},  32'(un0),   32'(eun0));
    chk({tag, " qe0"},   32'(qe0),   32'(eqe0));
    chk({tag, " isat0"}, 32'(isat0), 32'(0));
    chk({tag, " dsat0"}, 32'(dsat0), 32'(0));
    chk({tag, " ithr0"}, 32'(ithr0), 32'(e0 >= ITH));
    chk({tag, " dthr0"}, 32'(dthr0), 32'(e0 <= DTH));
    chk({tag, " q1"},    32'(q1),    32'(e1));
    chk({tag, " qs1"},   32'(qs1),   32'(e1));
    chk({tag, " ovf1"},  32'(ov1),   32'(eov1));
    chk({tag, " unf1"},  32'(un1),   32'(eun1));
    chk({tag, " qe1"},   32'(qe1),   32'(eqe1));
    chk({tag, " isat1"}, 32'(isat1), 32'(e1 == HI));
    chk({tag, " dsat1"}, 32'(dsat1), 32'(e1 == LO));
    chk({tag, " ithr1"}, 32'(ithr1), 32'(e1 >= ITH));
    chk({tag, " dthr1"}, 32'(dthr1), 32'(e1 <= DTH));
  endtask

  task automatic apply(input vec_t v);
    we = v.we;   wd = v.wd;  re = v.re;
    de = v.de;   d  = v.d;
    incr = v.incr; iv = v.iv;
    decr = v.decr; dv = v.dv;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  vec_t z;
  vec_t rv;
  res_t r0, r1;
  int   m0, m1;

  initial begin
    z = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00,
          8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    //          we   wd     re    de    d      incr  iv     decr  dv       e0    ov un qe    e1    ov un qe
    vt[0]  = '{1'b1, 8'hFE, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00,  8'hFE, 1'b0, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b1};
    vt[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 8'h03, 1'b0, 8'h00,  8'h01, 1'b1, 1'b0, 1'b0, 8'hF0, 1'b1, 1'b0, 1'b0};
    vt[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00,  8'h01, 1'b0, 1'b0, 1'b0, 8'hF0, 1'b0, 1'b0, 1'b0};
    vt[3]  = '{1'b1, 8'hEE, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00,  8'hEE, 1'b0, 1'b0, 1'b1, 8'hEE, 1'b0, 1'b0, 1'b1};
    vt[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 8'h05, 1'b0, 8'h00,  8'hF3, 1'b0, 1'b0, 1'b0, 8'hF0, 1'b1, 1'b0, 1'b0};
    vt[5]  = '{1'b1, 8'h02, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00,  8'h02, 1'b0, 1'b0, 1'b1, 8'h02, 1'b0, 1'b0, 1'b1};
    vt[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 8'h01, 1'b1, 8'h04,  8'hFF, 1'b0, 1'b1, 1'b0, 8'h08, 1'b0, 1'b1, 1'b0};
    vt[7]  = '{1'b1, 8'h55, 1'b0, 1'b1, 8'h11, 1'b1, 8'h01, 1'b0, 8'h00,  8'h55, 1'b0, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 1'b1};
    vt[8]  = '{1'b1, 8'h40, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00,  8'h40, 1'b0, 1'b0, 1'b1, 8'h40, 1'b0, 1'b0, 1'b1};
    vt[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 8'h01, 1'b0, 8'h00,  8'h41, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
    vt[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h11, 1'b1, 8'h01, 1'b0, 8'h00,  8'h11, 1'b0, 1'b0, 1'b0, 8'h11, 1'b0, 1'b0, 1'b0};
    vt[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 8'h00,  8'h11, 1'b0, 1'b0, 1'b0, 8'h11, 1'b0, 1'b0, 1'b0};
    vt[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 8'h02, 1'b1, 8'h02,  8'h11, 1'b0, 1'b0, 1'b0, 8'h11, 1'b0, 1'b0, 1'b0};
    vt[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h20,  8'hF1, 1'b0, 1'b1, 1'b0, 8'h08, 1'b0, 1'b1, 1'b0};
    vt[14] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00,  8'hF1, 1'b0, 1'b0, 1'b0, 8'h08, 1'b0, 1'b0, 1'b0};
    vt[15] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h01,  8'hF0, 1'b0, 1'b0, 1'b0, 8'h08, 1'b0, 1'b1, 1'b0};

    rst = 1'b1;
    apply(z);
    #12;
    check_all("reset", RV, 0, 0, 0, RV, 0, 0, 0);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      apply(vt[i]);
      step();
      check_all($sformatf("vec%0d", i),
                int'(vt[i].e0), vt[i].eov0, vt[i].eun0, vt[i].eqe0,
                int'(vt[i].e1), vt[i].eov1, vt[i].eun1, vt[i].eqe1);
    end

    // Raise an overflow pulse, then hit reset mid-cycle while incr is still asserted.
    rv = z; rv.we = 1'b1; rv.wd = 8'hFF;
    apply(rv);
    step();
    check_all("pre_rst_wr", 8'hFF, 0, 0, 1, 8'hFF, 0, 0, 1);
    rv = z; rv.incr = 1'b1; rv.iv = 8'h01;
    apply(rv);
    step();
    check_all("pre_rst_ovf", 8'h00, 1, 0, 0, HI, 1, 0, 0);
    #2 rst = 1'b1;
    #1;
    check_all("rst_async", RV, 0, 0, 0, RV, 0, 0, 0);
    step();
    check_all("rst_held", RV, 0, 0, 0, RV, 0, 0, 0);
    rst = 1'b0;
    step();
    check_all("rst_resume", RV + 1, 0, 0, 0, RV + 1, 0, 0, 0);
    m0 = RV + 1;
    m1 = RV + 1;

    for (int n = 0; n < 400; n++) begin
      rv      = z;
      rv.we   = ($urandom_range(0, 9) == 0);
      rv.wd   = 8'($urandom_range(0, 255));
      rv.re   = ($urandom_range(0, 7) == 0);
      rv.de   = ($urandom_range(0, 9) == 0);
      rv.d    = 8'($urandom_range(0, 255));
      rv.incr = ($urandom_range(0, 1) == 1);
      rv.iv   = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 3));
      rv.decr = ($urandom_range(0, 1) == 1);
      rv.dv   = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 3));
      r0 = model(m0, 1'b0, 1'b0, rv);
      r1 = model(m1, 1'b1, 1'b1, rv);
      apply(rv);
      step();
      check_all($sformatf("rnd%0d", n), r0.q, r0.ov, r0.un, r0.qe, r1.q, r1.ov, r1.un, r1.qe);
      m0 = r0.q;
      m1 = r1.q;
    end

    apply(z);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
